sm_imem_arbiter: RTL
====================

Name: sm_imem_arbiter

Overview:
- Shares one single-port instruction memory between N_CORES schoolRISCV cores.
- Arbitration is round-robin.
- A boot-loader write port has absolute priority; it programs per-node code such as 32'h00500293 at runtime instead of through initial blocks.
- Sits between the cores' instruction-fetch ports and a synchronous RAM that replaces the fixed-content instruction ROM.

Parameters:
- N_CORES, 4, number of fetch requesters.
- ADDR_W, 6, word-address width (64-word memory).
- DATA_W, 32, instruction width.
- BOOT_LOAD, 1, 1 = cores are blocked after reset until the loader finishes; 0 = start directly in RUN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- core_req  in  N_CORES  per-core fetch request; held until granted.
- core_addr  in  N_CORES*ADDR_W  packed word addresses; core i occupies bits [i*ADDR_W +: ADDR_W].
- core_gnt  out  N_CORES  one-hot grant, combinational, same cycle as the accepted request.
- core_rvalid  out  N_CORES  one-hot, one cycle after the grant.
- core_rdata  out  DATA_W  shared read data; valid where core_rvalid is set.
- ld_we  in  1  loader write strobe.
- ld_addr  in  ADDR_W  loader word address.
- ld_wdata  in  DATA_W  loader data.
- ld_last  in  1  qualifies ld_we: this is the final boot word.
- ld_count  out  ADDR_W+1  number of loader writes since reset; saturates.
- boot_done  out  1  high in RUN.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, 1-cycle latency after mem_en with !mem_we.

Behaviour:
- Reset values:
  - core_gnt=0, core_rvalid=0.
  - Round-robin pointer rr_ptr=0, ld_count=0.
  - State = LOAD if BOOT_LOAD else RUN; boot_done=(state==RUN).
  - mem_en=0, mem_we=0.
  - Any in-flight read is discarded: no rvalid after reset.
- FSM states: LOAD, RUN.
  - LOAD: all core_gnt forced to 0. The loader may write. ld_we with ld_last moves the FSM to RUN on the next edge.
  - RUN: terminal until rst.
- Loader priority (both states): when ld_we=1, drive mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_wdata. No core is granted that cycle and rr_ptr is unchanged.
- ld_count increments on every ld_we and saturates at 2^ADDR_W.
- ld_last without ld_we is ignored.
- Core arbitration (RUN, ld_we=0):
  - Scan core_req starting at rr_ptr, wrapping modulo N_CORES.
  - The first requester i gets core_gnt[i]=1, with mem_en=1, mem_we=0, mem_addr=core_addr[i].
  - rr_ptr <= (i+1) mod N_CORES.
  - At most one grant per cycle.
  - With no request: mem_en=0 and rr_ptr holds.
- Read return: a registered one-hot tag of the granted core drives core_rvalid on the next cycle. core_rdata = mem_rdata passed through combinationally.
- Throughput: back-to-back grants are allowed every cycle.
- Read-after-write: a write in cycle t followed by a read of the same address in t+1 returns the new data; this is a property of the RAM.
- Request rules:
  - A requester deasserting core_req before its grant is legal; it simply loses its turn.
  - core_addr must be stable while core_req=1 && !core_gnt. This is a bench assertion, not RTL.
- Reset while a grant is pending clears the rvalid tag; the data for that fetch is never delivered.
- mem_wdata = ld_wdata whenever mem_we=1; its value is don't-care otherwise (drive 0).

Decomposition:
- Shared package sm_imem_pkg holds:
  - state encoding (ST_LOAD, ST_RUN);
  - default ADDR_W/DATA_W constants;
  - a function for the round-robin search start index.
- One natural sub-module: sm_rr_arbiter (parameter N; inputs req and ptr; outputs one-hot gnt and the next pointer), purely combinational plus a pointer register.
- FSM, loader counter and rvalid tag stay in the top.

Test Plan:
- Boot load: BOOT_LOAD=1; reset; core_req=4'b1111 held.
  - Write 5 words, starting 32'h00500293 at addr 0, with ld_last on word 4.
  - No core_gnt until after the ld_last cycle; ld_count=5; boot_done rises the cycle after ld_last.
- Round robin: RUN; all four cores request continuously at addr 0.
  - Grants cycle 0001,0010,0100,1000,0001.
  - core_rvalid is the same pattern delayed one cycle; core_rdata=32'h00500293.
- Loader preemption: RUN; core 2 requests; ld_we pulses for one cycle at addr 3 with 32'hfe000ae3.
  - No grant that cycle; core 2 is granted next cycle; a read of addr 3 returns 32'hfe000ae3.
- Sparse and wrap: rr_ptr=3 after a grant to core 2; only core 1 requests.
  - Core 1 is granted via wrap-around and rr_ptr becomes 2.
  - Idle cycles leave mem_en=0 and rr_ptr unchanged.
- Reset mid-fetch: grant core 0, then assert rst the next edge.
  - core_rvalid stays 0; state returns to LOAD; ld_count=0.
- Saturation: ADDR_W=2; 6 loader writes -> ld_count=4.

Source files
------------

// File: rtl/sm_imem_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
// State encoding, default widths and the round-robin scan index.
package sm_imem_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int N_CORES_DEF = 4;
    localparam int ADDR_W_DEF  = 6;
    localparam int DATA_W_DEF  = 32;

    // Index of the k-th candidate when scanning from ptr, wrapping at n.
    function automatic int rr_idx(int ptr, int k, int n);
        return (ptr + k) % n;
    endfunction

endpackage

// File: rtl/sm_imem_arbiter_if.sv
// Fetch bus between the cores and the instruction-memory arbiter.
// master: cores (req/addr out; gnt/rvalid/rdata in); slave: arbiter.
interface sm_imem_arbiter_if #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32
);
    logic [N_CORES-1:0]        core_req;
    logic [N_CORES*ADDR_W-1:0] core_addr;
    logic [N_CORES-1:0]        core_gnt;
    logic [N_CORES-1:0]        core_rvalid;
    logic [DATA_W-1:0]         core_rdata;

    modport master (
        output core_req, core_addr,
        input  core_gnt, core_rvalid, core_rdata
    );

    modport slave (
        input  core_req, core_addr,
        output core_gnt, core_rvalid, core_rdata
    );
endinterface

// File: rtl/sm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from req, scanning from ptr.
// Ports: clk, rst, req[N] in; gnt[N] one-hot out, ptr out.
module sm_rr_arbiter
    import sm_imem_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PW'(rr_idx(int'(ptr), k, N));
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_nxt  = PW'(rr_idx(int'(idx), 1, N));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else     ptr <= ptr_nxt;
    end

endmodule

// File: rtl/sm_imem_arbiter.sv
// Shares one single-port instruction RAM among N_CORES fetch ports.
// Ports: clk, rst, bus (fetch slave), ld_* loader, mem_* RAM side,
// ld_count, boot_done. Loader writes always win over core fetches.
module sm_imem_arbiter
    import sm_imem_pkg::*;
#(
    parameter int N_CORES   = N_CORES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit BOOT_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    sm_imem_arbiter_if.slave  bus,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_last,
    output logic [ADDR_W:0]   ld_count,
    output logic              boot_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam state_t ST_RST = BOOT_LOAD ? ST_LOAD : ST_RUN;

    state_t               state, state_nxt;
    logic [N_CORES-1:0]   arb_req;
    logic [N_CORES-1:0]   gnt;
    logic [N_CORES-1:0]   tag_q;
    logic [PW-1:0]        rr_ptr;
    logic [ADDR_W-1:0]    fetch_addr;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RST;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_LOAD: if (ld_we && ld_last) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_RST;
        endcase
    end

    // Cores only compete in RUN and only when the loader is idle.
    always_comb begin
        boot_done = (state == ST_RUN);
        arb_req   = '0;
        if (state == ST_RUN && !ld_we) arb_req = bus.core_req;
    end

    sm_rr_arbiter #(.N(N_CORES)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (arb_req),
        .gnt (gnt),
        .ptr (rr_ptr)
    );

    always_comb begin
        fetch_addr = '0;
        for (int i = 0; i < N_CORES; i++)
            if (gnt[i]) fetch_addr = bus.core_addr[i*ADDR_W +: ADDR_W];
    end

    always_comb begin
        mem_en    = ld_we | (|gnt);
        mem_we    = ld_we;
        mem_addr  = ld_we ? ld_addr : fetch_addr;
        mem_wdata = ld_we ? ld_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_count <= '0;
            tag_q    <= '0;
        end else begin
            if (ld_we && ld_count != CNT_MAX) ld_count <= ld_count + 1'b1;
            tag_q <= gnt;
        end
    end

    assign bus.core_gnt    = gnt;
    assign bus.core_rvalid = tag_q;
    assign bus.core_rdata  = mem_rdata;

    logic unused_ptr;
    assign unused_ptr = ^rr_ptr;

endmodule
